// File: rtl/sys_defs.sv
// Shared definitions for the branch predictor: sizes and the table entry layout.
package sys_defs;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BPW  = 32;
  localparam int unsigned IDXW = $clog2(BPW);
  localparam int unsigned TAGW = XLEN - IDXW - 2;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic            direction;
    logic [XLEN-1:0] target_pc;
  } BP_ENTRY_PACKET;

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped branch target/direction table with 3-wide fetch lookup and dispatch allocation.
// Defining BRANCH_PREDICTOR_DEBUG_PORT_EN adds the bp_entries_display table view port.
module branch_predictor
  import sys_defs::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 update_EN,
  input  logic [XLEN-1:0]      update_pc,
  input  logic                 update_direction,
  input  logic [XLEN-1:0]      update_target,
  input  logic [2:0]           dispatch_EN,
  input  logic [3*XLEN-1:0]    dispatch_pc,
  input  logic [2:0]           fetch_EN,
  input  logic [3*XLEN-1:0]    fetch_pc,
  output logic [2:0]           predict_direction,
  output logic [3*XLEN-1:0]    predict_pc
`ifdef BRANCH_PREDICTOR_DEBUG_PORT_EN
  ,
  output BP_ENTRY_PACKET [BPW-1:0] bp_entries_display
`endif
);

  BP_ENTRY_PACKET [BPW-1:0] entries_q;
  BP_ENTRY_PACKET [BPW-1:0] entries_d;

  logic [2:0][XLEN-1:0] fetch_pc_v;
  logic [2:0][XLEN-1:0] dispatch_pc_v;
  logic [2:0][XLEN-1:0] predict_pc_v;
  logic [2:0]           fetch_hit;
  logic                 unused_update_pc_low;

  assign fetch_pc_v           = fetch_pc;
  assign dispatch_pc_v        = dispatch_pc;
  assign predict_pc           = predict_pc_v;
  assign unused_update_pc_low = ^update_pc[1:0];

  // Lookup reads only the registered table; reset forces a fall-through prediction.
  always_comb begin
    fetch_hit         = 3'b000;
    predict_direction = 3'b000;
    predict_pc_v      = '0;
    for (int i = 0; i < 3; i++) begin
      fetch_hit[i] = fetch_EN[i] & ~reset
                   & entries_q[fetch_pc_v[i][IDXW+1:2]].valid
                   & (entries_q[fetch_pc_v[i][IDXW+1:2]].tag == fetch_pc_v[i][XLEN-1:IDXW+2]);
      predict_direction[i] = fetch_hit[i] & entries_q[fetch_pc_v[i][IDXW+1:2]].direction;
      predict_pc_v[i] = predict_direction[i] ? entries_q[fetch_pc_v[i][IDXW+1:2]].target_pc
                                             : fetch_pc_v[i] + XLEN'(4);
    end
  end

  // Dispatch slots apply in ascending order so the highest slot wins; update is applied last.
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < 3; i++) begin
      if (dispatch_EN[i] &&
          !(entries_q[dispatch_pc_v[i][IDXW+1:2]].valid &&
            entries_q[dispatch_pc_v[i][IDXW+1:2]].tag == dispatch_pc_v[i][XLEN-1:IDXW+2])) begin
        entries_d[dispatch_pc_v[i][IDXW+1:2]].valid     = 1'b1;
        entries_d[dispatch_pc_v[i][IDXW+1:2]].tag       = dispatch_pc_v[i][XLEN-1:IDXW+2];
        entries_d[dispatch_pc_v[i][IDXW+1:2]].direction = 1'b0;
        entries_d[dispatch_pc_v[i][IDXW+1:2]].target_pc = dispatch_pc_v[i] + XLEN'(4);
      end
    end
    if (update_EN) begin
      entries_d[update_pc[IDXW+1:2]].valid     = 1'b1;
      entries_d[update_pc[IDXW+1:2]].tag       = update_pc[XLEN-1:IDXW+2];
      entries_d[update_pc[IDXW+1:2]].direction = update_direction;
      entries_d[update_pc[IDXW+1:2]].target_pc = update_target;
    end
    if (reset) begin
      entries_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    entries_q <= entries_d;
  end

`ifdef BRANCH_PREDICTOR_DEBUG_PORT_EN
  assign bp_entries_display = entries_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor: train/dispatch steps followed by 3-slot lookups.
module tb_branch_predictor;

  localparam int unsigned XW = 32;

  logic              clock;
  logic              reset;
  logic              update_EN;
  logic [XW-1:0]     update_pc;
  logic              update_direction;
  logic [XW-1:0]     update_target;
  logic [2:0]        dispatch_EN;
  logic [3*XW-1:0]   dispatch_pc;
  logic [2:0]        fetch_EN;
  logic [3*XW-1:0]   fetch_pc;
  logic [2:0]        predict_direction;
  logic [3*XW-1:0]   predict_pc;

  int total;
  int bad;

  branch_predictor dut (
    .clock             (clock),
    .reset             (reset),
    .update_EN         (update_EN),
    .update_pc         (update_pc),
    .update_direction  (update_direction),
    .update_target     (update_target),
    .dispatch_EN       (dispatch_EN),
    .dispatch_pc       (dispatch_pc),
    .fetch_EN          (fetch_EN),
    .fetch_pc          (fetch_pc),
    .predict_direction (predict_direction),
    .predict_pc        (predict_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         name;
    logic          ue;
    logic [XW-1:0] upc;
    logic          udir;
    logic [XW-1:0] utgt;
    logic [2:0]    de;
    logic [3*XW-1:0] dpc;
    logic [2:0]    fe;
    logic [3*XW-1:0] fpc;
    logic [2:0]    edir;
    logic [3*XW-1:0] epc;
  } vec_t;

  function automatic vec_t mk(input string name,
                              input logic ue, input logic [XW-1:0] upc,
                              input logic udir, input logic [XW-1:0] utgt,
                              input logic [2:0] de,
                              input logic [XW-1:0] d0, input logic [XW-1:0] d1, input logic [XW-1:0] d2,
                              input logic [2:0] fe,
                              input logic [XW-1:0] f0, input logic [XW-1:0] f1, input logic [XW-1:0] f2,
                              input logic [2:0] edir,
                              input logic [XW-1:0] e0, input logic [XW-1:0] e1, input logic [XW-1:0] e2);
    vec_t v;
    v.name = name; v.ue = ue; v.upc = upc; v.udir = udir; v.utgt = utgt;
    v.de = de; v.dpc = {d2, d1, d0};
    v.fe = fe; v.fpc = {f2, f1, f0};
    v.edir = edir; v.epc = {e2, e1, e0};
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] edir, input logic [3*XW-1:0] epc);
    total++;
    if (predict_direction !== edir) begin
      bad++;
      $display("FAIL %s dir: got %b want %b", name, predict_direction, edir);
    end
    total++;
    if (predict_pc !== epc) begin
      bad++;
      $display("FAIL %s pc: got %h want %h", name, predict_pc, epc);
    end
  endtask

  task automatic clear_writes();
    update_EN = 1'b0; update_pc = '0; update_direction = 1'b0; update_target = '0;
    dispatch_EN = 3'b000; dispatch_pc = '0;
  endtask

  task automatic set_fetch(input logic [2:0] fe, input logic [XW-1:0] f0,
                           input logic [XW-1:0] f1, input logic [XW-1:0] f2);
    fetch_EN = fe;
    fetch_pc = {f2, f1, f0};
  endtask

  vec_t vecs[$];

  initial begin
    total = 0;
    bad   = 0;
    clear_writes();

    vecs.push_back(mk("dispatch_4_8_12", 0, 0, 0, 0, 3'b111, 4, 8, 12,
                      3'b111, 4, 8, 12, 3'b000, 8, 12, 16));
    vecs.push_back(mk("update4_dispatch16_24", 1, 4, 1, 80, 3'b011, 16, 24, 0,
                      3'b111, 4, 8, 16, 3'b001, 80, 12, 20));
    vecs.push_back(mk("redispatch_4_low_bits", 0, 0, 0, 0, 3'b001, 4, 0, 0,
                      3'b111, 4, 5, 7, 3'b111, 80, 80, 80));
    vecs.push_back(mk("fetch_en_gating", 0, 0, 0, 0, 3'b000, 0, 0, 0,
                      3'b010, 4, 4, 4, 3'b010, 8, 80, 8));
    vecs.push_back(mk("dispatch_36", 0, 0, 0, 0, 3'b001, 36, 0, 0,
                      3'b001, 36, 0, 0, 3'b000, 40, 4, 4));
    vecs.push_back(mk("update_36_taken", 1, 36, 1, 200, 3'b000, 0, 0, 0,
                      3'b111, 36, 4, 164, 3'b011, 200, 80, 168));
    vecs.push_back(mk("dispatch_164_replace", 0, 0, 0, 0, 3'b001, 164, 0, 0,
                      3'b111, 36, 164, 4, 3'b100, 40, 168, 80));
    vecs.push_back(mk("update_164_taken", 1, 164, 1, 300, 3'b000, 0, 0, 0,
                      3'b111, 164, 36, 4, 3'b101, 300, 40, 80));
    vecs.push_back(mk("dispatch_164_hit_slot2", 0, 0, 0, 0, 3'b100, 0, 0, 164,
                      3'b111, 164, 36, 4, 3'b101, 300, 40, 80));
    vecs.push_back(mk("update_dispatch_same_idx", 1, 12, 1, 32'h1000, 3'b111, 12, 140, 268,
                      3'b111, 12, 140, 268, 3'b001, 32'h1000, 144, 272));
    vecs.push_back(mk("update_not_taken", 1, 4, 0, 80, 3'b000, 0, 0, 0,
                      3'b111, 4, 12, 0, 3'b010, 8, 32'h1000, 4));
    vecs.push_back(mk("wrap_and_train_top", 1, 32'hFFFF_FFF8, 1, 32'h40, 3'b000, 0, 0, 0,
                      3'b111, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 4, 3'b010, 0, 32'h40, 8));

    // Reset held: lookups must fall through while the table clears.
    reset = 1'b1;
    set_fetch(3'b111, 4, 8, 12);
    #1;
    check("during_reset", 3'b000, {32'd16, 32'd12, 32'd8});
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("after_reset", 3'b000, {32'd16, 32'd12, 32'd8});

    foreach (vecs[k]) begin
      update_EN = vecs[k].ue; update_pc = vecs[k].upc;
      update_direction = vecs[k].udir; update_target = vecs[k].utgt;
      dispatch_EN = vecs[k].de; dispatch_pc = vecs[k].dpc;
      @(posedge clock); #1;
      clear_writes();
      fetch_EN = vecs[k].fe; fetch_pc = vecs[k].fpc;
      #1;
      check(vecs[k].name, vecs[k].edir, vecs[k].epc);
    end

    // Mid-run reset with a concurrent update: reset must win and outputs fall through at once.
    reset = 1'b1;
    update_EN = 1'b1; update_pc = 12; update_direction = 1'b1; update_target = 32'h2000;
    set_fetch(3'b111, 12, 32'hFFFF_FFF8, 36);
    #1;
    check("reset_asserted_outputs", 3'b000, {32'd40, 32'hFFFF_FFFC, 32'd16});
    @(posedge clock); #1;
    reset = 1'b0;
    clear_writes();
    #1;
    check("after_midrun_reset", 3'b000, {32'd40, 32'hFFFF_FFFC, 32'd16});

    // Table is writable again after reset.
    update_EN = 1'b1; update_pc = 12; update_direction = 1'b1; update_target = 32'h2000;
    @(posedge clock); #1;
    clear_writes();
    #1;
    check("retrain_after_reset", 3'b001, {32'd40, 32'hFFFF_FFFC, 32'h2000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL use parameter/constant XLEN, default 32: width of all PC and target values.
REQ-002 SHALL use parameter/constant BPW, default 32: number of entries (power of two); IDXW = log2(BPW).
REQ-003 SHALL have port clock, input, 1 bit: all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the clock rising edge.
REQ-005 SHALL have port update_EN, input, 1 bit: resolved-branch update valid.
REQ-006 SHALL have port update_pc, input, XLEN bits: PC of the resolved branch.
REQ-007 SHALL have port update_direction, input, 1 bit: 1 = taken.
REQ-008 SHALL have port update_target, input, XLEN bits: resolved taken target.
REQ-009 SHALL have port dispatch_EN, input, 3 bits: per-slot valid flag; the instruction in that slot is a branch being dispatched.
REQ-010 SHALL have port dispatch_pc, input, 3 x XLEN bits: per-slot dispatched PC.
REQ-011 SHALL have port fetch_EN, input, 3 bits: per-slot fetch lookup valid.
REQ-012 SHALL have port fetch_pc, input, 3 x XLEN bits: per-slot fetch PC.
REQ-013 SHALL have port predict_direction, output, 3 bits: per-slot predicted taken.
REQ-014 SHALL have port predict_pc, output, 3 x XLEN bits: per-slot predicted next PC.
REQ-015 SHALL have port bp_entries_display, output, BPW x BP_ENTRY_PACKET: current table contents; present only when the macro of REQ-030 is defined.

Function
REQ-016 SHALL hold a direct-mapped table of BPW entries; each entry holds {valid, tag, direction, target_pc}.
REQ-017 SHALL compute index as pc[IDXW+1:2] and tag as pc[XLEN-1:IDXW+2]; pc[1:0] is ignored.
REQ-018 SHALL produce fetch outputs combinationally from the current table state, with no same-cycle bypass from updates or dispatches.
REQ-019 SHALL set hit = fetch_EN[i] & valid & tag match; predict_direction[i] = hit & direction.
REQ-020 SHALL set predict_pc[i] = target_pc when predict_direction[i] = 1, else fetch_pc[i]+4 (this includes fetch_EN[i] = 0).
REQ-021 SHALL, on dispatch_EN[i], allocate the indexed entry on the next edge if it is invalid or its tag differs: valid = 1, tag written, direction = 0, target_pc = dispatch_pc[i]+4.
REQ-022 SHALL leave the entry unchanged when a dispatch hits a valid entry with a matching tag.
REQ-023 SHALL, when several dispatch slots map to the same index in one cycle, give the highest-numbered slot priority.
REQ-024 SHALL, on update_EN, write the indexed entry on the next edge with valid = 1, tag, direction = update_direction and target_pc = update_target; this also allocates on a miss.
REQ-025 SHALL, when an update and a dispatch target the same index in one cycle, apply the update last, so the update wins.
REQ-026 SHALL perform all arithmetic (+4) modulo 2^XLEN.

Reset
REQ-027 SHALL, on reset, clear all entries to zero (valid = 0, tag = 0, direction = 0, target_pc = 0) on the next rising edge.
REQ-028 SHALL, while reset is asserted, drive predict_direction = 0 and predict_pc[i] = fetch_pc[i]+4.
REQ-029 SHALL give reset priority over concurrent update and dispatch.

Configuration
REQ-030 SHALL expose the bp_entries_display port, driven continuously with the table contents, when BRANCH_PREDICTOR_DEBUG_PORT_EN is defined; when it is undefined the port SHALL be absent and table behaviour SHALL be identical.

Structure
REQ-031 SHALL define BP_ENTRY_PACKET (valid, tag, direction, target_pc), XLEN and BPW in the shared sys_defs package.
REQ-032 SHALL be a single flat module with no sub-modules.

Verification
REQ-033 SHALL cover: after reset, fetch PCs 4/8/12 -> predict_direction = 000, predict_pc = 8/12/16, all entries invalid.
REQ-034 SHALL cover: dispatch 4/8/12 -> entries 1/2/3 valid, direction 0, targets 8/12/16; then fetch 4/8/12 -> not taken.
REQ-035 SHALL cover: update pc = 4, taken, target 80 (with dispatch of 16/24 in the same cycle) -> next cycle fetch 4 gives direction 1, predict_pc 80; fetch 8 gives predict_pc 12.
REQ-036 SHALL cover: re-dispatch of pc 4 after training -> entry 1 keeps direction 1 and target 80.
REQ-037 SHALL cover: dispatch 36 (index 9) -> entry 9 allocated; then dispatch 164 (same index, new tag) -> entry 9 replaced with target 168 and direction 0.
REQ-038 SHALL cover: update and dispatch to the same index in one cycle -> update values stored; reset asserted mid-run -> all entries invalid next cycle.
